// File: rtl/fp_mul_pkg.sv
// Shared types for the streaming FP32 multiplier driver.
// Holds the driver FSM encoding and the operand pair carried through the request FIFO.
package fp_mul_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2,
    WAIT_Z = 2'd3
  } state_t;

  typedef struct packed {
    logic [FP32_W-1:0] a;
    logic [FP32_W-1:0] b;
  } fp_ops_t;

endpackage

// File: rtl/fp_multiplier_booth_csa.sv
// FP32 multiplier core with a/b/z strobe-ack handshakes, round-to-nearest-even.
// Latency: one compute cycle after operand B is taken; z_stb then holds until acked.
// Backpressure: no new operand A is acked until the result has been taken.
module fp_multiplier_booth_csa (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [1:0] {GET_A, GET_B, CALC, PUT_Z} core_state_t;

  core_state_t st;
  logic [31:0] a_r;
  logic [31:0] b_r;

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0] ma, mb;
    logic [47:0] prod, norm;
    logic [95:0] wide;
    logic [30:0] mag;
    logic        g, sticky;
    logic [31:0] r;
    int          lz, en, sh;
    s      = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    a_nan  = (ea == 8'hff) && (fa != '0);
    b_nan  = (eb == 8'hff) && (fb != '0);
    a_inf  = (ea == 8'hff) && (fa == '0);
    b_inf  = (eb == 8'hff) && (fb == '0);
    a_zero = (ea == 8'h00) && (fa == '0);
    b_zero = (eb == 8'h00) && (fb == '0);
    ma     = {ea != 8'h00, fa};
    mb     = {eb != 8'h00, fb};
    prod   = {24'd0, ma} * {24'd0, mb};
    lz = 48;
    for (int i = 47; i >= 0; i--) begin
      if (prod[i] && lz == 48) lz = 47 - i;
    end
    norm = prod << lz;
    // Biased exponent of the value once the leading one sits at bit 47.
    en = int'((ea == 8'h00) ? 8'd1 : ea) + int'((eb == 8'h00) ? 8'd1 : eb) - 126 - lz;
    sh = (en <= 0) ? 1 - en : 0;
    if (sh > 49) sh = 49;
    wide   = {norm, 48'd0} >> sh;
    g      = wide[71];
    sticky = |wide[70:0];
    // Subnormal results have the leading one shifted out of bit 95, so the field is 0;
    // a rounding carry out of the fraction then lands in the exponent as required.
    mag = {(wide[95] ? en[7:0] : 8'd0), wide[94:72]};
    mag = mag + 31'(g && (sticky || wide[72]));
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = 32'h7fc00000;
    else if (a_inf || b_inf)                                      r = {s, 8'hff, 23'd0};
    else if (a_zero || b_zero)                                    r = {s, 31'd0};
    else if (en >= 255)                                           r = {s, 8'hff, 23'd0};
    else                                                          r = {s, mag};
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= GET_A;
      input_a_ack  <= 1'b1;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a_r          <= '0;
      b_r          <= '0;
    end else begin
      case (st)
        GET_A: if (input_a_stb && input_a_ack) begin
          a_r         <= input_a;
          input_a_ack <= 1'b0;
          input_b_ack <= 1'b1;
          st          <= GET_B;
        end
        GET_B: if (input_b_stb && input_b_ack) begin
          b_r         <= input_b;
          input_b_ack <= 1'b0;
          st          <= CALC;
        end
        CALC: begin
          output_z     <= fp_mul(a_r, b_r);
          output_z_stb <= 1'b1;
          st           <= PUT_Z;
        end
        PUT_Z: if (output_z_stb && output_z_ack) begin
          output_z_stb <= 1'b0;
          input_a_ack  <= 1'b1;
          st           <= GET_A;
        end
        default: st <= GET_A;
      endcase
    end
  end

endmodule

// File: rtl/fp_req_fifo.sv
// Generic request FIFO: power-of-two DEPTH entries of W bits, show-ahead read port.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is honoured when not full or when a pop happens in the same cycle.
module fp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_stream_driver.sv
// Streams tagged FP32 multiply requests through one core, results returned in order.
// Latency: SEND_A two cycles after acceptance into an empty FIFO; result core latency + 1.
// Backpressure: res_ready low stalls the core in WAIT_Z, then the FIFO fills and drops req_ready.
module fp_mul_stream_driver
  import fp_mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [FP32_W-1:0]      req_a,
  input  logic [FP32_W-1:0]      req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FP32_W-1:0]      res_z,
  output logic [TAG_W-1:0]       res_tag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       done_count
);

  typedef struct packed {
    fp_ops_t          ops;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t            state;
  req_t              push_req;
  req_t              head;
  req_t              cur;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              a_stb, a_ack;
  logic              b_stb, b_ack;
  logic [FP32_W-1:0] core_z;
  logic              z_stb, z_ack;
  logic              core_rst;

  assign push_req  = {req_a, req_b, req_tag};
  assign req_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign z_ack     = (state == WAIT_Z) && (!res_valid || res_ready);
  assign busy      = (state != IDLE) || !fifo_empty || res_valid;
  assign core_rst  = ~rst_n;

  fp_req_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * FP32_W + TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_valid && req_ready),
    .push_dat (push_req),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  fp_multiplier_booth_csa u_core (
    .clk          (clk),
    .rst          (core_rst),
    .input_a      (cur.ops.a),
    .input_a_stb  (a_stb),
    .input_a_ack  (a_ack),
    .input_b      (cur.ops.b),
    .input_b_stb  (b_stb),
    .input_b_ack  (b_ack),
    .output_z     (core_z),
    .output_z_stb (z_stb),
    .output_z_ack (z_ack)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      a_stb      <= 1'b0;
      b_stb      <= 1'b0;
      res_valid  <= 1'b0;
      res_z      <= '0;
      res_tag    <= '0;
      done_count <= '0;
    end else begin
      if (res_valid && res_ready) begin
        res_valid  <= 1'b0;
        done_count <= done_count + CNT_W'(1);
      end
      case (state)
        IDLE: if (!fifo_empty) begin
          cur   <= head;
          a_stb <= 1'b1;
          state <= SEND_A;
        end
        SEND_A: if (a_stb && a_ack) begin
          a_stb <= 1'b0;
          b_stb <= 1'b1;
          state <= SEND_B;
        end
        SEND_B: if (b_stb && b_ack) begin
          b_stb <= 1'b0;
          state <= WAIT_Z;
        end
        // A reload here overrides the clear above, so a same-cycle handoff keeps res_valid high.
        WAIT_Z: if (z_stb && z_ack) begin
          res_z     <= core_z;
          res_tag   <= cur.tag;
          res_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_stream_driver.sv
// Directed bench for fp_mul_stream_driver: hand-computed products, ordering, backpressure, reset.
module tb_fp_mul_stream_driver;
  import fp_mul_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int NV    = 41;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_z;
  logic [3:0]  res_tag;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [3:0]  done_count;

  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [31:0] vz [NV];
  logic [3:0]  vt [NV];
  logic [35:0] got [$];

  int total = 0;
  int bad = 0;
  int exp_done = 0;
  int max_level = 0;
  int acc;
  int cnt;

  fp_mul_stream_driver #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_z      (res_z),
    .res_tag    (res_tag),
    .busy       (busy),
    .fifo_level (fifo_level),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) got.push_back({res_z, res_tag});
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic setv(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] z, input logic [3:0] t);
    va[i] = a; vb[i] = b; vz[i] = z; vt[i] = t;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers vectors first..first+num-1 in order; req_ready is stable between edges.
  task automatic stream(input int first, input int num, input int cycles, output int accepted);
    logic rdy;
    accepted = 0;
    for (int c = 0; c < cycles && accepted < num; c++) begin
      req_valid = 1'b1;
      req_a     = va[first + accepted];
      req_b     = vb[first + accepted];
      req_tag   = vt[first + accepted];
      rdy       = req_ready;
      @(posedge clk); #1;
      if (rdy) accepted++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
    req_valid = 1'b0;
  endtask

  task automatic stream_hold(input int first, input int num, input int cycles, output int accepted);
    logic rdy;
    accepted = 0;
    for (int c = 0; c < cycles; c++) begin
      req_valid = (accepted < num);
      req_a     = va[first + ((accepted < num) ? accepted : num - 1)];
      req_b     = vb[first + ((accepted < num) ? accepted : num - 1)];
      req_tag   = vt[first + ((accepted < num) ? accepted : num - 1)];
      rdy       = req_ready;
      @(posedge clk); #1;
      if (rdy && accepted < num) accepted++;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 400 && got.size() < n; c++) begin @(posedge clk); #1; end
    chk("result_count", 64'(got.size()), 64'(n));
  endtask

  task automatic check_results(input string name, input int first, input int n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_%0d", name, i), 64'(got[i]), 64'({vz[first + i], vt[first + i]}));
    got.delete();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0; res_ready = 1'b0;

    setv(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'd3);
    setv(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'd0);
    setv(2, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'd1);
    setv(3, 32'h00000000, 32'h40A00000, 32'h00000000, 4'd2);
    setv(4, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'd3);
    // k.0 * 2.0 for k = 1..8
    setv(5,  32'h3F800000, 32'h40000000, 32'h40000000, 4'd0);
    setv(6,  32'h40000000, 32'h40000000, 32'h40800000, 4'd1);
    setv(7,  32'h40400000, 32'h40000000, 32'h40C00000, 4'd2);
    setv(8,  32'h40800000, 32'h40000000, 32'h41000000, 4'd3);
    setv(9,  32'h40A00000, 32'h40000000, 32'h41200000, 4'd4);
    setv(10, 32'h40C00000, 32'h40000000, 32'h41400000, 4'd5);
    setv(11, 32'h40E00000, 32'h40000000, 32'h41600000, 4'd6);
    setv(12, 32'h41000000, 32'h40000000, 32'h41800000, 4'd7);
    // k.0 * 1.0 for k = 1..8
    setv(13, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'd8);
    setv(14, 32'h40000000, 32'h3F800000, 32'h40000000, 4'd9);
    setv(15, 32'h40400000, 32'h3F800000, 32'h40400000, 4'd10);
    setv(16, 32'h40800000, 32'h3F800000, 32'h40800000, 4'd11);
    setv(17, 32'h40A00000, 32'h3F800000, 32'h40A00000, 4'd12);
    setv(18, 32'h40C00000, 32'h3F800000, 32'h40C00000, 4'd13);
    setv(19, 32'h40E00000, 32'h3F800000, 32'h40E00000, 4'd14);
    setv(20, 32'h41000000, 32'h3F800000, 32'h41000000, 4'd15);
    setv(21, 32'h40000000, 32'h40400000, 32'h40C00000, 4'd1);
    setv(22, 32'h40000000, 32'h40400000, 32'h40C00000, 4'd2);
    setv(23, 32'h40000000, 32'h40400000, 32'h40C00000, 4'd3);
    setv(24, 32'h40000000, 32'h40400000, 32'h40C00000, 4'd5);
    for (int i = 0; i < 16; i++) setv(25 + i, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'(i));

    cyc(3);
    chk("rst_res_valid",  64'(res_valid),  64'(0));
    chk("rst_fifo_level", 64'(fifo_level), 64'(0));
    chk("rst_done_count", 64'(done_count), 64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_res_z",      64'(res_z),      64'(0));
    chk("rst_res_tag",    64'(res_tag),    64'(0));
    chk("rst_req_ready",  64'(req_ready),  64'(1));
    rst_n = 1'b1;
    cyc(2);

    // Single op
    res_ready = 1'b1;
    stream(0, 1, 20, acc);
    chk("single_accept", 64'(acc), 64'(1));
    chk("single_level",  64'(fifo_level), 64'(1));
    chk("single_busy",   64'(busy), 64'(1));
    cyc(1);
    chk("single_popped", 64'(fifo_level), 64'(0));
    wait_results(1);
    check_results("single", 0, 1);
    exp_done += 1;
    chk("single_done", 64'(done_count), 64'(exp_done % 16));
    chk("single_res_valid_clr", 64'(res_valid), 64'(0));

    // Back-to-back stream of four
    stream(1, 4, 20, acc);
    chk("b2b_accept", 64'(acc), 64'(4));
    wait_results(4);
    check_results("b2b", 1, 4);
    exp_done += 4;
    chk("b2b_done", 64'(done_count), 64'(exp_done % 16));

    // Backpressure: eight offered, six fit
    res_ready = 1'b0;
    stream_hold(5, 8, 40, acc);
    chk("bp_accept",    64'(acc), 64'(6));
    chk("bp_req_ready", 64'(req_ready), 64'(0));
    chk("bp_level",     64'(fifo_level), 64'(4));
    chk("bp_res_valid", 64'(res_valid), 64'(1));
    chk("bp_res_z",     64'(res_z), 64'(vz[5]));
    cyc(5);
    chk("bp_res_z_hold",   64'(res_z), 64'(vz[5]));
    chk("bp_res_tag_hold", 64'(res_tag), 64'(vt[5]));
    chk("bp_no_handoff",   64'(got.size()), 64'(0));
    res_ready = 1'b1;
    wait_results(6);
    check_results("bp", 5, 6);
    exp_done += 6;
    chk("bp_done", 64'(done_count), 64'(exp_done % 16));
    cyc(3);
    chk("bp_idle", 64'(busy), 64'(0));

    // Fill to full, then keep pushing while the queue drains
    res_ready = 1'b0;
    stream(13, 6, 40, acc);
    chk("full_accept", 64'(acc), 64'(6));
    chk("full_level",  64'(fifo_level), 64'(4));
    res_ready = 1'b1;
    max_level = 0;
    stream(19, 2, 60, acc);
    chk("full_extra_accept", 64'(acc), 64'(2));
    chk("full_level_bound",  64'(max_level <= DEPTH), 64'(1));
    wait_results(8);
    check_results("full", 13, 8);
    exp_done += 8;
    chk("full_done", 64'(done_count), 64'(exp_done % 16));

    // Reset with a pending result, an op in SEND_B and one queued
    res_ready = 1'b0;
    stream(21, 3, 40, acc);
    chk("rst_mid_accept", 64'(acc), 64'(3));
    for (int c = 0; c < 100 && !res_valid; c++) cyc(1);
    for (int c = 0; c < 100 && dut.state != SEND_B; c++) cyc(1);
    chk("rst_mid_in_send_b", 64'(dut.state == SEND_B), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_res_valid", 64'(res_valid), 64'(0));
    chk("rst_mid_level",     64'(fifo_level), 64'(0));
    chk("rst_mid_done",      64'(done_count), 64'(0));
    chk("rst_mid_busy",      64'(busy), 64'(0));
    exp_done = 0;
    got.delete();
    cyc(2);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin cyc(1); if (res_valid) cnt++; end
    chk("rst_mid_no_res", 64'(cnt), 64'(0));
    res_ready = 1'b1;
    stream(24, 1, 20, acc);
    wait_results(1);
    check_results("post_rst", 24, 1);
    exp_done += 1;
    chk("post_rst_done", 64'(done_count), 64'(exp_done % 16));

    // Sixteen more ops: 17 since reset wraps the 4-bit counter to 1
    stream(25, 16, 300, acc);
    chk("wrap_accept", 64'(acc), 64'(16));
    wait_results(16);
    check_results("wrap", 25, 16);
    exp_done += 16;
    chk("wrap_done", 64'(done_count), 64'(exp_done % 16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
